// File: rtl/xs3_dec_stream_if.sv
// Stream bundle for the excess-3 decoder: a digit input channel, a word output
// channel and the running invalid-digit count.
interface xs3_dec_stream_if #(
  parameter int DIGITS = 4,
  parameter int ERRW   = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            in_xs3;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_bcd;
  logic [DIGITS-1:0]     out_bad_mask;
  logic                  out_err;
  logic [ERRW-1:0]       err_cnt;

  // Environment side: produces digits and consumes words.
  modport master (
    output in_valid, in_xs3, out_ready,
    input  in_ready, out_valid, out_bcd, out_bad_mask, out_err, err_cnt
  );

  // Decoder side.
  modport slave (
    input  in_valid, in_xs3, out_ready,
    output in_ready, out_valid, out_bcd, out_bad_mask, out_err, err_cnt
  );
endinterface

// File: rtl/xs3_dec_stream.sv
// Serial excess-3 to packed-BCD decoder: collects DIGITS codes MSD first, then
// holds the assembled word with per-digit invalid flags until it is taken.
module xs3_dec_stream #(
  parameter int DIGITS = 4,
  parameter int ERRW   = 8
) (
  input  logic              clk,
  input  logic              rst,
  xs3_dec_stream_if.slave   bus
);

  localparam int                 CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(DIGITS - 1);

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_dig_cnt;
  logic [CNT_W-1:0]      w_dig_cnt_nxt;
  logic [4*DIGITS-1:0]   r_bcd;
  logic [4*DIGITS-1:0]   w_bcd_nxt;
  logic [DIGITS-1:0]     r_mask;
  logic [DIGITS-1:0]     w_mask_nxt;
  logic [ERRW-1:0]       r_err_cnt;
  logic [ERRW-1:0]       w_err_cnt_nxt;
  logic                  r_in_ready;
  logic                  r_out_valid;

  logic                  w_code_ok;
  logic [3:0]            w_nib;
  logic [CNT_W-1:0]      w_slot;

  // Valid excess-3 codes are 3..12; anything else decodes to the F marker.
  assign w_code_ok = (bus.in_xs3 >= 4'd3) && (bus.in_xs3 <= 4'd12);
  assign w_nib     = w_code_ok ? (bus.in_xs3 - 4'd3) : 4'hF;
  assign w_slot    = LAST - r_dig_cnt;

  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_dig_cnt_nxt = r_dig_cnt;
    w_bcd_nxt     = r_bcd;
    w_mask_nxt    = r_mask;
    w_err_cnt_nxt = r_err_cnt;

    unique case (r_state)
      ST_COLLECT: begin
        if (bus.in_valid) begin
          for (int k = 0; k < DIGITS; k++) begin
            if (w_slot == CNT_W'(k)) begin
              w_bcd_nxt[4*k +: 4] = w_nib;
              w_mask_nxt[k]       = ~w_code_ok;
            end
          end

          if (!w_code_ok && (r_err_cnt != {ERRW{1'b1}})) begin
            w_err_cnt_nxt = r_err_cnt + 1'b1;
          end

          if (r_dig_cnt == LAST) begin
            w_dig_cnt_nxt = '0;
            w_state_nxt   = ST_HOLD;
          end else begin
            w_dig_cnt_nxt = r_dig_cnt + 1'b1;
          end
        end
      end

      ST_HOLD: begin
        // The word is frozen until taken; the next word starts from a clean slate.
        if (bus.out_ready) begin
          w_state_nxt = ST_COLLECT;
          w_bcd_nxt   = '0;
          w_mask_nxt  = '0;
        end
      end

      default: begin
        w_state_nxt = ST_COLLECT;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: the data word is reset too, because out_bcd is a visible output
  // that must read zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_COLLECT;
      r_dig_cnt   <= '0;
      r_bcd       <= '0;
      r_mask      <= '0;
      r_err_cnt   <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_dig_cnt   <= w_dig_cnt_nxt;
      r_bcd       <= w_bcd_nxt;
      r_mask      <= w_mask_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
      r_in_ready  <= (w_state_nxt == ST_COLLECT);
      r_out_valid <= (w_state_nxt == ST_HOLD);
    end
  end

  assign bus.in_ready     = r_in_ready;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_bcd      = r_bcd;
  assign bus.out_bad_mask = r_mask;
  assign bus.out_err      = |r_mask;
  assign bus.err_cnt      = r_err_cnt;

endmodule

// File: tb/tb_xs3_dec_stream.sv
// Directed bench for xs3_dec_stream: a word table plus hand sequences for
// back-pressure, streaming cadence, mid-word reset and counter saturation.
module tb_xs3_dec_stream;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  xs3_dec_stream_if #(.DIGITS(4), .ERRW(8)) b1 ();
  xs3_dec_stream_if #(.DIGITS(4), .ERRW(2)) b2 ();

  xs3_dec_stream #(.DIGITS(4), .ERRW(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  xs3_dec_stream #(.DIGITS(4), .ERRW(2)) u_dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (b2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] codes;  // four XS-3 codes, first-sent in the top nibble
    logic [15:0] bcd;
    logic [3:0]  mask;
    logic [7:0]  err;    // cumulative err_cnt after this word
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [3:0] code);
    b1.in_valid = 1'b1;
    b1.in_xs3   = code;
    step();
    b1.in_valid = 1'b0;
  endtask

  initial begin
    int pulses;
    total = 0;
    bad   = 0;

    vecs[0] = '{codes: 16'h4567, bcd: 16'h1234, mask: 4'b0000, err: 8'd0};
    vecs[1] = '{codes: 16'h0123, bcd: 16'hFFF0, mask: 4'b1110, err: 8'd3};
    vecs[2] = '{codes: 16'h4567, bcd: 16'h1234, mask: 4'b0000, err: 8'd3};
    vecs[3] = '{codes: 16'h89AB, bcd: 16'h5678, mask: 4'b0000, err: 8'd3};
    vecs[4] = '{codes: 16'hCDEF, bcd: 16'h9FFF, mask: 4'b0111, err: 8'd6};

    b1.in_valid = 1'b0; b1.in_xs3 = 4'd0; b1.out_ready = 1'b0;
    b2.in_valid = 1'b0; b2.in_xs3 = 4'd0; b2.out_ready = 1'b1;
    rst = 1'b1;
    #12;
    check("rst_in_ready",  32'(b1.in_ready), 32'd1);
    check("rst_out_valid", 32'(b1.out_valid), 32'd0);
    check("rst_bcd",       32'(b1.out_bcd), 32'h0);
    check("rst_mask",      32'(b1.out_bad_mask), 32'h0);
    check("rst_err",       32'(b1.out_err), 32'd0);
    check("rst_err_cnt",   32'(b1.err_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Single word with the consumer always ready: out_valid is a one-cycle pulse.
    b1.out_ready = 1'b1;
    send1(4'd4); send1(4'd5); send1(4'd6); send1(4'd7);
    check("t1_valid", 32'(b1.out_valid), 32'd1);
    check("t1_bcd",   32'(b1.out_bcd), 32'h1234);
    check("t1_mask",  32'(b1.out_bad_mask), 32'h0);
    check("t1_err",   32'(b1.out_err), 32'd0);
    check("t1_ready", 32'(b1.in_ready), 32'd0);
    step();
    check("t1_valid_drop", 32'(b1.out_valid), 32'd0);
    check("t1_bcd_clear",  32'(b1.out_bcd), 32'h0);
    b1.out_ready = 1'b0;

    // Word table; each word is held one cycle before being taken.
    for (int v = 0; v < 5; v++) begin
      for (int j = 0; j < 4; j++) begin
        logic [15:0] c;
        c = vecs[v].codes;
        send1(c[15-4*j -: 4]);
      end
      check($sformatf("v%0d_valid", v), 32'(b1.out_valid), 32'd1);
      check($sformatf("v%0d_bcd", v),   32'(b1.out_bcd), 32'(vecs[v].bcd));
      check($sformatf("v%0d_mask", v),  32'(b1.out_bad_mask), 32'(vecs[v].mask));
      check($sformatf("v%0d_err", v),   32'(b1.out_err), 32'(vecs[v].mask != 4'b0));
      check($sformatf("v%0d_cnt", v),   32'(b1.err_cnt), 32'(vecs[v].err));
      b1.out_ready = 1'b1;
      step();
      b1.out_ready = 1'b0;
      check($sformatf("v%0d_taken", v), 32'(b1.out_valid), 32'd0);
      check($sformatf("v%0d_clear", v), 32'(b1.out_bad_mask), 32'h0);
    end

    // Back-pressure: word held five cycles while new digits are offered and dropped.
    send1(4'd12); send1(4'd3); send1(4'd8); send1(4'd11);
    b1.in_valid = 1'b1;
    b1.in_xs3   = 4'd4;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t3_valid_%0d", i), 32'(b1.out_valid), 32'd1);
      check($sformatf("t3_bcd_%0d", i),   32'(b1.out_bcd), 32'h9058);
      check($sformatf("t3_ready_%0d", i), 32'(b1.in_ready), 32'd0);
      step();
    end
    b1.in_valid  = 1'b0;
    b1.out_ready = 1'b1;
    step();
    check("t3_release_valid", 32'(b1.out_valid), 32'd0);
    check("t3_release_ready", 32'(b1.in_ready), 32'd1);
    check("t3_release_bcd",   32'(b1.out_bcd), 32'h0);
    check("t3_cnt_kept",      32'(b1.err_cnt), 32'd6);
    send1(4'd4); send1(4'd5); send1(4'd6); send1(4'd7);
    check("t3_next_word", 32'(b1.out_bcd), 32'h1234);
    step();

    // Streaming cadence: one word every five cycles.
    pulses = 0;
    b1.in_valid = 1'b1;
    b1.in_xs3   = 4'd4;
    for (int i = 1; i <= 20; i++) begin
      step();
      check($sformatf("t4_valid_c%0d", i), 32'(b1.out_valid), 32'((i % 5) == 4));
      if (b1.out_valid) begin
        pulses++;
        check($sformatf("t4_bcd_c%0d", i), 32'(b1.out_bcd), 32'h1111);
      end
    end
    check("t4_pulses", 32'(pulses), 32'd4);
    b1.in_valid = 1'b0;
    step();
    step();

    // Mid-word asynchronous reset discards the partial word.
    send1(4'd4); send1(4'd5);
    rst = 1'b1;
    #1;
    check("t5_rst_bcd",   32'(b1.out_bcd), 32'h0);
    check("t5_rst_valid", 32'(b1.out_valid), 32'd0);
    check("t5_rst_ready", 32'(b1.in_ready), 32'd1);
    check("t5_rst_cnt",   32'(b1.err_cnt), 32'd0);
    check("t5_rst_mask",  32'(b1.out_bad_mask), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step();
    send1(4'd6); send1(4'd7); send1(4'd8); send1(4'd9);
    check("t5_valid", 32'(b1.out_valid), 32'd1);
    check("t5_bcd",   32'(b1.out_bcd), 32'h3456);
    step();

    // Two-bit error counter saturates at 3.
    b2.in_xs3 = 4'd15;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] exp_cnt [4];
      exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3};
      b2.in_valid = 1'b1;
      step();
      check($sformatf("t6_cnt_%0d", i), 32'(b2.err_cnt), 32'(exp_cnt[i]));
    end
    b2.in_valid = 1'b0;
    check("t6_mask", 32'(b2.out_bad_mask), 32'hF);
    check("t6_bcd",  32'(b2.out_bcd), 32'hFFFF);
    check("t6_err",  32'(b2.out_err), 32'd1);
    step();
    b2.in_valid = 1'b1;
    step();
    b2.in_valid = 1'b0;
    check("t6_cnt_4", 32'(b2.err_cnt), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
